// File: rtl/piso_reg_if.sv
// Parallel-load / serial-out handshake bundle: word side (par_*) and bit side (ser_*).
// No latency of its own; pure wiring between source, serializer and sink.
// Backpressure: par_ready gates word loads, ser_ready stalls the serial stream.
interface piso_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             ser_data;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_last;
    logic             busy;

    // Word source and bit sink side
    modport master (
        output par_data, par_valid, ser_ready,
        input  par_ready, ser_data, ser_valid, ser_last, busy
    );

    // Serializer side
    modport slave (
        input  par_data, par_valid, ser_ready,
        output par_ready, ser_data, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/piso_reg.sv
// Parallel-in serial-out serializer with valid/ready on both sides; optional even parity bit via PISO_PARITY_EN.
// Latency: first frame bit on ser_data one cycle after the load edge; frames chain with no idle cycle.
// Backpressure: ser_ready=0 freezes the current bit; par_ready only in IDLE or on the accepted last bit.
module piso_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         arst_n,
    piso_reg_if.slave    bus
);

`ifdef PISO_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [N-1:0]     shreg;
    logic [N-1:0]     shreg_nxt;
    logic [N-1:0]     frame;
    logic [WIDTH-1:0] ordered;
    logic             is_last;
    logic             xfer;
    logic             done;
    logic             load;

    // The frame is held in transmission order so the outgoing bit is always shreg[N-1].
    always_comb begin
        ordered = bus.par_data;
        if (!MSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                ordered[i] = bus.par_data[WIDTH-1-i];
            end
        end
    end

`ifdef PISO_PARITY_EN
    assign frame = {ordered, ^bus.par_data};
`else
    assign frame = ordered;
`endif

    assign is_last = (state == SHIFT) && (cnt == CW'(N - 1));
    assign xfer    = (state == SHIFT) && bus.ser_ready;
    assign done    = xfer && is_last;
    // ser_ready reaches par_ready combinationally so the next word can load on the last-bit edge.
    assign bus.par_ready = arst_n && ((state == IDLE) || done);
    assign load          = bus.par_valid && bus.par_ready;

    assign bus.ser_valid = (state == SHIFT);
    assign bus.ser_data  = (state == SHIFT) && shreg[N-1];
    assign bus.ser_last  = is_last;
    assign bus.busy      = (state == SHIFT);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        shreg_nxt = shreg;
        case (state)
            IDLE: begin
                if (load) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    shreg_nxt = frame;
                end
            end
            SHIFT: begin
                if (xfer) begin
                    if (is_last) begin
                        cnt_nxt = '0;
                        if (load) begin
                            shreg_nxt = frame;
                        end else begin
                            state_nxt = IDLE;
                            shreg_nxt = '0;
                        end
                    end else begin
                        cnt_nxt   = cnt + CW'(1);
                        shreg_nxt = shreg << 1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                shreg_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= IDLE;
            cnt   <= '0;
            shreg <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            shreg <= shreg_nxt;
        end
    end

endmodule

// File: doc/piso_reg.md
PISO_REG -- requirements
Module: piso_reg

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1, serial bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 par_data  input  WIDTH  parallel word to serialize.
REQ-006 par_valid  input  1  par_data valid.
REQ-007 par_ready  output  1  block can accept a word this cycle.
REQ-008 ser_data  output  1  current serial bit.
REQ-009 ser_valid  output  1  ser_data valid.
REQ-010 ser_ready  input  1  sink accepts ser_data this cycle.
REQ-011 ser_last  output  1  current bit is the final bit of the frame.
REQ-012 busy  output  1  frame in progress (state SHIFT).

Function
REQ-013 Load handshake: a word is accepted on a rising edge where par_valid=1 and par_ready=1; par_valid is ignored when par_ready=0.
REQ-014 Bit transfer: one serial bit is consumed on a rising edge where ser_valid=1 and ser_ready=1; ser_data and ser_last hold stable while ser_valid=1 and ser_ready=0.
REQ-015 FSM states: IDLE (ser_valid=0) and SHIFT (ser_valid=1).
REQ-016 IDLE -> SHIFT on load; the first frame bit appears on ser_data the cycle after the load edge (latency 1).
REQ-017 Frame length N = WIDTH bits (without parity); the bit counter is $clog2(N+1) bits wide and counts 0..N-1.
REQ-018 ser_last = 1 exactly when the counter equals N-1 in SHIFT.
REQ-019 par_ready = arst_n AND (state==IDLE OR (ser_valid AND ser_ready AND ser_last)); combinational path from ser_ready to par_ready.
REQ-020 Last-bit transfer with par_valid=1: the new word loads on the same edge, state stays SHIFT, the counter returns to 0, and the next frame starts with no idle cycle.
REQ-021 Last-bit transfer with par_valid=0: SHIFT -> IDLE, and ser_valid drops on the next cycle.
REQ-022 No load is possible in SHIFT before the last-bit transfer; the frame in flight is never corrupted.
REQ-023 The bit order follows MSB_FIRST and is fixed per frame from the word latched at load.
REQ-024 In IDLE, ser_data=0 and ser_last=0.

Reset
REQ-025 While arst_n=0: state=IDLE, counter=0, shift register=0, ser_data=0, ser_valid=0, ser_last=0, busy=0, par_ready=0.
REQ-026 Reset assertion mid-frame aborts the frame immediately and asynchronously; the remaining bits are discarded.
REQ-027 par_ready=1 from the first cycle after arst_n deasserts.

Configuration
REQ-028 Macro PISO_PARITY_EN: when defined, N = WIDTH+1, and bit N-1 is the even parity (XOR of all WIDTH data bits) computed at load; ser_last accompanies the parity bit.
REQ-029 PISO_PARITY_EN undefined: N = WIDTH, and no parity logic is instantiated.

Verification (WIDTH=8, MSB_FIRST=1 unless stated)
REQ-030 Load 0xA5 with ser_ready held 1 -> ser_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after the load; ser_last is 1 only on the 8th cycle; ser_valid then drops. With PISO_PARITY_EN, a 9th bit = 0 carries ser_last.
REQ-031 Back-to-back: 0xA5 then 0x3C, par_valid held 1 -> 16 gapless bits 10100101 00111100; par_ready=1 only in IDLE and on the 8th-bit cycle.
REQ-032 Backpressure: load 0xC3 with ser_ready alternating 1,0,1,0... -> bits 11000011 each held across stall cycles; frame completes in 16 cycles; par_ready stays 0 until the last-bit transfer.
REQ-033 Reset mid-frame: load 0xFF, assert arst_n after 3 transfers -> ser_valid=0 and par_ready=0 immediately; after release, load 0x81 -> clean frame 10000001.
REQ-034 MSB_FIRST=0: load 0x01 -> ser_data 1 then seven 0s; with PISO_PARITY_EN, parity bit = 1.
REQ-035 PISO_PARITY_EN: load 0x07 -> data bits 00000111 then parity bit 1 with ser_last; load 0x00 -> parity bit 0.
